// File: rtl/sargantana_icache_refill_ctrl.sv
// ============================================================================
// sargantana_icache_refill_ctrl
//   Owns the icache array write port: line refills from IFILL and invalidations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sargantana_icache_refill_ctrl #(
  parameter int N_WAY     = 4,
  parameter int DEPTH     = 128,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int TAG_W     = 20,
  parameter int PADDR_W   = 27,
  parameter int LINE_W    = 256,
  parameter int LAST_BEAT = 3,
  parameter int WAY_W     = $clog2(N_WAY)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               miss_valid_i,
  output logic               miss_ready_o,
  input  logic [PADDR_W-1:0] miss_paddr_i,
  input  logic [WAY_W-1:0]   miss_way_i,
  input  logic               kill_i,
  input  logic               inval_valid_i,
  output logic               inval_ready_o,
  input  logic               inval_all_i,
  input  logic [IDX_W-1:0]   inval_idx_i,
  input  logic [WAY_W-1:0]   inval_way_i,
  output logic               ifill_req_valid_o,
  output logic [WAY_W-1:0]   ifill_req_way_o,
  output logic [PADDR_W-1:0] ifill_req_paddr_o,
  input  logic               ifill_ack_i,
  input  logic               ifill_resp_valid_i,
  input  logic [1:0]         ifill_resp_beat_i,
  input  logic [LINE_W-1:0]  ifill_resp_data_i,
  output logic               wr_en_o,
  output logic [N_WAY-1:0]   wr_way_o,
  output logic [IDX_W-1:0]   wr_idx_o,
  output logic [TAG_W-1:0]   wr_tag_o,
  output logic               wr_vbit_o,
  output logic [LINE_W-1:0]  wr_data_o,
  output logic               done_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_WRITE     = 3'd3,
    S_DRAIN     = 3'd4,
    S_INV_ONE   = 3'd5,
    S_INV_ALL   = 3'd6
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_inv_cnt;
  logic             w_idle;
  logic             w_last;

  function automatic logic [N_WAY-1:0] f_onehot(input logic [WAY_W-1:0] way);
    f_onehot      = '0;
    f_onehot[way] = 1'b1;
  endfunction

  assign w_idle        = (r_state == S_IDLE);
  assign w_last        = ifill_resp_valid_i && (ifill_resp_beat_i == 2'(LAST_BEAT));
  assign miss_ready_o  = w_idle & ~inval_valid_i & ~rst_i;
  assign inval_ready_o = w_idle & ~rst_i;
  assign busy_o        = ~w_idle;

  // The IFILL request registers double as the latched miss address/way.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state           <= S_IDLE;
      r_inv_cnt         <= '0;
      ifill_req_valid_o <= 1'b0;
      ifill_req_way_o   <= '0;
      ifill_req_paddr_o <= '0;
      wr_en_o           <= 1'b0;
      wr_way_o          <= '0;
      wr_idx_o          <= '0;
      wr_tag_o          <= '0;
      wr_vbit_o         <= 1'b0;
      wr_data_o         <= '0;
      done_o            <= 1'b0;
    end else begin
      wr_en_o   <= 1'b0;
      wr_way_o  <= '0;
      wr_idx_o  <= '0;
      wr_tag_o  <= '0;
      wr_vbit_o <= 1'b0;
      wr_data_o <= '0;
      done_o    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (inval_valid_i) begin
            wr_en_o <= 1'b1;
            if (inval_all_i) begin
              wr_way_o  <= '1;
              r_inv_cnt <= '0;
              r_state   <= S_INV_ALL;
            end else begin
              wr_way_o <= f_onehot(inval_way_i);
              wr_idx_o <= inval_idx_i;
              r_state  <= S_INV_ONE;
            end
          end else if (miss_valid_i) begin
            ifill_req_valid_o <= 1'b1;
            ifill_req_way_o   <= miss_way_i;
            ifill_req_paddr_o <= miss_paddr_i;
            r_state           <= S_REQ;
          end
        end

        S_REQ: begin
          if (kill_i) begin
            ifill_req_valid_o <= 1'b0;
            r_state           <= (ifill_ack_i && !w_last) ? S_DRAIN : S_IDLE;
          end else if (ifill_ack_i) begin
            ifill_req_valid_o <= 1'b0;
            if (w_last) begin
              wr_en_o   <= 1'b1;
              wr_way_o  <= f_onehot(ifill_req_way_o);
              wr_idx_o  <= ifill_req_paddr_o[IDX_W-1:0];
              wr_tag_o  <= ifill_req_paddr_o[PADDR_W-1 -: TAG_W];
              wr_vbit_o <= 1'b1;
              wr_data_o <= ifill_resp_data_i;
              done_o    <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_state <= S_WAIT_RESP;
            end
          end
        end

        S_WAIT_RESP: begin
          if (kill_i) begin
            r_state <= w_last ? S_IDLE : S_DRAIN;
          end else if (w_last) begin
            wr_en_o   <= 1'b1;
            wr_way_o  <= f_onehot(ifill_req_way_o);
            wr_idx_o  <= ifill_req_paddr_o[IDX_W-1:0];
            wr_tag_o  <= ifill_req_paddr_o[PADDR_W-1 -: TAG_W];
            wr_vbit_o <= 1'b1;
            wr_data_o <= ifill_resp_data_i;
            done_o    <= 1'b1;
            r_state   <= S_WRITE;
          end
        end

        S_WRITE:   r_state <= S_IDLE;
        S_INV_ONE: r_state <= S_IDLE;

        S_DRAIN: begin
          if (w_last) r_state <= S_IDLE;
        end

        S_INV_ALL: begin
          if (r_inv_cnt == IDX_W'(DEPTH - 1)) begin
            r_inv_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_inv_cnt <= r_inv_cnt + 1'b1;
            wr_en_o   <= 1'b1;
            wr_way_o  <= '1;
            wr_idx_o  <= r_inv_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// ============================================================================
// tb_sargantana_icache_refill_ctrl
//   Directed bench with a transaction-level reference model of the refill controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sargantana_icache_refill_ctrl;

  localparam int DEPTH = 128;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         miss_valid_i = 1'b0;
  logic         miss_ready_o;
  logic [26:0]  miss_paddr_i = '0;
  logic [1:0]   miss_way_i = '0;
  logic         kill_i = 1'b0;
  logic         inval_valid_i = 1'b0;
  logic         inval_ready_o;
  logic         inval_all_i = 1'b0;
  logic [6:0]   inval_idx_i = '0;
  logic [1:0]   inval_way_i = '0;
  logic         ifill_req_valid_o;
  logic [1:0]   ifill_req_way_o;
  logic [26:0]  ifill_req_paddr_o;
  logic         ifill_ack_i = 1'b0;
  logic         ifill_resp_valid_i = 1'b0;
  logic [1:0]   ifill_resp_beat_i = '0;
  logic [255:0] ifill_resp_data_i = '0;
  logic         wr_en_o;
  logic [3:0]   wr_way_o;
  logic [6:0]   wr_idx_o;
  logic [19:0]  wr_tag_o;
  logic         wr_vbit_o;
  logic [255:0] wr_data_o;
  logic         done_o;
  logic         busy_o;

  sargantana_icache_refill_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_paddr_i(miss_paddr_i), .miss_way_i(miss_way_i), .kill_i(kill_i),
    .inval_valid_i(inval_valid_i), .inval_ready_o(inval_ready_o),
    .inval_all_i(inval_all_i), .inval_idx_i(inval_idx_i), .inval_way_i(inval_way_i),
    .ifill_req_valid_o(ifill_req_valid_o), .ifill_req_way_o(ifill_req_way_o),
    .ifill_req_paddr_o(ifill_req_paddr_o), .ifill_ack_i(ifill_ack_i),
    .ifill_resp_valid_i(ifill_resp_valid_i), .ifill_resp_beat_i(ifill_resp_beat_i),
    .ifill_resp_data_i(ifill_resp_data_i),
    .wr_en_o(wr_en_o), .wr_way_o(wr_way_o), .wr_idx_o(wr_idx_o), .wr_tag_o(wr_tag_o),
    .wr_vbit_o(wr_vbit_o), .wr_data_o(wr_data_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one pending refill transaction plus a queue of array
  // writes that must appear on consecutive cycles.
  typedef struct packed {
    logic         en;
    logic [3:0]   way;
    logic [6:0]   idx;
    logic [19:0]  tag;
    logic         vbit;
    logic [255:0] data;
  } wr_t;

  function automatic wr_t mk_wr(input logic [3:0] way, input logic [6:0] idx,
                                input logic [19:0] tag, input logic vbit,
                                input logic [255:0] data);
    wr_t w;
    w.en = 1'b1; w.way = way; w.idx = idx; w.tag = tag; w.vbit = vbit; w.data = data;
    return w;
  endfunction

  wr_t         m_q[$];
  wr_t         m_cur = '0;
  int          m_txn = 0;  // 0 none, 1 requesting, 2 acked, 3 killed after ack
  logic [26:0] m_paddr = '0;
  logic [1:0]  m_way = '0;
  bit          m_idle;
  bit          m_last;

  initial forever begin
    @(negedge clk_i);
    m_idle = (m_txn == 0) && !m_cur.en;
    if (chk_en) begin
      chk("wr_en", 256'(wr_en_o), 256'(m_cur.en));
      chk("wr_way", 256'(wr_way_o), 256'(m_cur.way));
      chk("wr_idx", 256'(wr_idx_o), 256'(m_cur.idx));
      chk("wr_tag", 256'(wr_tag_o), 256'(m_cur.tag));
      chk("wr_vbit", 256'(wr_vbit_o), 256'(m_cur.vbit));
      chk("wr_data", wr_data_o, m_cur.data);
      chk("done", 256'(done_o), 256'(m_cur.en & m_cur.vbit));
      chk("req_valid", 256'(ifill_req_valid_o), 256'(m_txn == 1));
      if (m_txn == 1) begin
        chk("req_paddr", 256'(ifill_req_paddr_o), 256'(m_paddr));
        chk("req_way", 256'(ifill_req_way_o), 256'(m_way));
      end
      chk("busy", 256'(busy_o), 256'((m_txn != 0) || m_cur.en));
      chk("inval_ready", 256'(inval_ready_o), 256'(m_idle && !rst_i));
      chk("miss_ready", 256'(miss_ready_o), 256'(m_idle && !inval_valid_i && !rst_i));
    end
    // Advance the model with the inputs the DUT sees at the next rising edge.
    m_last = ifill_resp_valid_i && (ifill_resp_beat_i == 2'd3);
    if (rst_i) begin
      m_txn = 0;
      m_q.delete();
      m_cur = '0;
    end else begin
      if (m_idle) begin
        if (inval_valid_i) begin
          if (inval_all_i)
            for (int i = 0; i < DEPTH; i++) m_q.push_back(mk_wr(4'hF, 7'(i), '0, 1'b0, '0));
          else
            m_q.push_back(mk_wr(4'b0001 << inval_way_i, inval_idx_i, '0, 1'b0, '0));
        end else if (miss_valid_i) begin
          m_txn = 1; m_paddr = miss_paddr_i; m_way = miss_way_i;
        end
      end else begin
        case (m_txn)
          1: if (kill_i) m_txn = (ifill_ack_i && !m_last) ? 3 : 0;
             else if (ifill_ack_i) begin
               if (m_last) begin
                 m_q.push_back(mk_wr(4'b0001 << m_way, m_paddr[6:0], m_paddr[26:7], 1'b1, ifill_resp_data_i));
                 m_txn = 0;
               end else m_txn = 2;
             end
          2: if (kill_i) m_txn = m_last ? 0 : 3;
             else if (m_last) begin
               m_q.push_back(mk_wr(4'b0001 << m_way, m_paddr[6:0], m_paddr[26:7], 1'b1, ifill_resp_data_i));
               m_txn = 0;
             end
          3: if (m_last) m_txn = 0;
          default: ;
        endcase
      end
      m_cur = (m_q.size() != 0) ? m_q.pop_front() : '0;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_miss(input logic [26:0] p, input logic [1:0] w);
    miss_valid_i = 1'b1; miss_paddr_i = p; miss_way_i = w;
    step();
    miss_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [1:0] b, input logic [255:0] d);
    ifill_resp_valid_i = 1'b1; ifill_resp_beat_i = b; ifill_resp_data_i = d;
    step();
    ifill_resp_valid_i = 1'b0;
  endtask

  logic [255:0] d1, d2, d3;
  int cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d1 = {4{64'hDEAD_BEEF_0123_4567}};
    d2 = {8{32'hA5A5_0F0F}};
    d3 = {16{16'h1357}};
    step();
    chk_en = 1'b1;
    step(); step();
    chk("reset_busy", 256'(busy_o), 256'(0));
    chk("reset_wr_en", 256'(wr_en_o), 256'(0));
    rst_i = 1'b0;

    // Basic refill: ack on the third REQ cycle, four beats.
    do_miss(27'h0123456, 2'd2);
    chk("t1_req_valid", 256'(ifill_req_valid_o), 256'(1));
    step(); step();
    ifill_ack_i = 1'b1; step(); ifill_ack_i = 1'b0;
    beat(2'd0, d2); beat(2'd1, d3); beat(2'd2, d2); beat(2'd3, d1);
    chk("t1_wr_en", 256'(wr_en_o), 256'(1));
    chk("t1_wr_way", 256'(wr_way_o), 256'(4'b0100));
    chk("t1_wr_idx", 256'(wr_idx_o), 256'(7'h56));
    chk("t1_wr_tag", 256'(wr_tag_o), 256'(20'h02468));
    chk("t1_wr_vbit", 256'(wr_vbit_o), 256'(1));
    chk("t1_done", 256'(done_o), 256'(1));
    chk("t1_data", wr_data_o, d1);
    step();
    chk("t1_after_wr_en", 256'(wr_en_o), 256'(0));

    // Whole-cache invalidation.
    inval_valid_i = 1'b1; inval_all_i = 1'b1;
    step();
    inval_valid_i = 1'b0; inval_all_i = 1'b0;
    cnt = 0;
    while (wr_en_o === 1'b1 && cnt < 200) begin cnt++; step(); end
    chk("t2_inval_all_writes", 256'(cnt), 256'(128));
    chk("t2_inval_ready", 256'(inval_ready_o), 256'(1));

    // Miss and invalidation together: invalidation first.
    miss_valid_i = 1'b1; miss_paddr_i = 27'h5ABCDEF; miss_way_i = 2'd3;
    inval_valid_i = 1'b1; inval_idx_i = 7'd5; inval_way_i = 2'd1;
    step();
    inval_valid_i = 1'b0;
    chk("t3_inv_way", 256'(wr_way_o), 256'(4'b0010));
    chk("t3_inv_idx", 256'(wr_idx_o), 256'(7'd5));
    chk("t3_inv_vbit", 256'(wr_vbit_o), 256'(0));
    step();
    chk("t3_miss_ready", 256'(miss_ready_o), 256'(1));
    step();
    miss_valid_i = 1'b0;
    chk("t3_req_paddr", 256'(ifill_req_paddr_o), 256'(27'h5ABCDEF));
    ifill_ack_i = 1'b1; ifill_resp_valid_i = 1'b1; ifill_resp_beat_i = 2'd3; ifill_resp_data_i = d2;
    step();
    ifill_ack_i = 1'b0; ifill_resp_valid_i = 1'b0;
    chk("t3_wr_tag", 256'(wr_tag_o), 256'(20'hB579B));
    chk("t3_wr_idx", 256'(wr_idx_o), 256'(7'h6F));
    chk("t3_wr_way", 256'(wr_way_o), 256'(4'b1000));
    step();

    // Kill before ack; stray last beat in IDLE must be ignored.
    do_miss(27'h0000081, 2'd0);
    kill_i = 1'b1; step(); kill_i = 1'b0;
    chk("t4_req_dropped", 256'(ifill_req_valid_o), 256'(0));
    chk("t4_idle", 256'(busy_o), 256'(0));
    beat(2'd3, d3);
    chk("t4_no_write", 256'(wr_en_o), 256'(0));

    // Kill in WAIT_RESP: drained, no write.
    do_miss(27'h1234567, 2'd1);
    ifill_ack_i = 1'b1; step(); ifill_ack_i = 1'b0;
    kill_i = 1'b1; step(); kill_i = 1'b0;
    chk("t5_draining", 256'(busy_o), 256'(1));
    beat(2'd1, d2); beat(2'd3, d1);
    chk("t5_no_done", 256'(done_o), 256'(0));
    chk("t5_idle", 256'(busy_o), 256'(0));

    // Kill together with ack, then a normal refill with kill during WRITE.
    do_miss(27'h0F0F0F0, 2'd3);
    ifill_ack_i = 1'b1; kill_i = 1'b1; step(); ifill_ack_i = 1'b0; kill_i = 1'b0;
    beat(2'd3, d1);
    do_miss(27'h7FFFFFF, 2'd0);
    ifill_ack_i = 1'b1; step(); ifill_ack_i = 1'b0;
    beat(2'd2, d1); beat(2'd3, d3);
    kill_i = 1'b1;
    chk("t5c_write_despite_kill", 256'(wr_en_o), 256'(1));
    step(); kill_i = 1'b0;

    // Reset while waiting for a response.
    do_miss(27'h0042000, 2'd3);
    ifill_ack_i = 1'b1; step(); ifill_ack_i = 1'b0;
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("t6_busy", 256'(busy_o), 256'(0));
    chk("t6_req_valid", 256'(ifill_req_valid_o), 256'(0));
    beat(2'd3, d2);
    chk("t6_no_write", 256'(wr_en_o), 256'(0));
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
